bcd_serial_addsub: RTL and testbench

- Parametrised, digit-serial BCD adder/subtractor for N-digit signed-magnitude results. Successor to the 2-digit combinational BCD add/ten's-complement path.
- Processes one BCD digit per clock, least significant digit first, and reuses a single digit adder with decimal correction.
- On subtraction, a second ten's-complement pass restores the magnitude of negative results and reports the sign.
- Sits between the switch/operand registers and the 7-segment display decoders. Uses a start/done handshake.

---
 rtl/bcd_serial_addsub_if.sv | 25 ++
 rtl/bcd_serial_addsub.sv | 168 ++++++++++++++++
 tb/tb_bcd_serial_addsub.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_serial_addsub_if.sv
// Start/done handshake and operand/result bundle for the digit-serial BCD adder/subtractor.
interface bcd_serial_addsub_if #(
   parameter int unsigned DIGITS = 4
);
   logic                  start;
   logic                  op;
   logic [4*DIGITS-1:0]   a;
   logic [4*DIGITS-1:0]   b;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   result;
   logic                  sign;
   logic                  overflow;
   logic                  invalid;

   modport master (
      output start, op, a, b,
      input  busy, done, result, sign, overflow, invalid
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, sign, overflow, invalid
   );
endinterface

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD add/subtract, LSD first, with a ten's-complement pass that turns a
// negative difference into sign + magnitude.
module bcd_serial_addsub #(
   parameter int unsigned DIGITS = 4
) (
   input logic               clk,
   input logic               rst,
   bcd_serial_addsub_if.slave bus
);
   localparam int unsigned W    = 4 * DIGITS;
   localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StCalc = 2'd1;
   localparam logic [1:0] StNeg  = 2'd2;
   localparam logic [1:0] StDone = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            carry_q, carry_d;
   logic            op_q, op_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    result_q, result_d;
   logic            sign_q, sign_d;
   logic            ovf_q, ovf_d;
   logic            inv_q, inv_d;

   logic [3:0] a_dig, b_dig, r_dig, x_dig, y_dig, sum_dig;
   logic [4:0] s_bin, s_cor;
   logic       cout;
   logic       last;
   int unsigned idx;

   function automatic logic has_bad_digit(input logic [W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   // Shared digit adder: CALC adds a_i to b_i (or 9-b_i); NEG adds 0 to 9-result_i.
   always_comb begin
      idx   = 32'(cnt_q);
      a_dig = a_q[4*idx +: 4];
      b_dig = b_q[4*idx +: 4];
      r_dig = result_q[4*idx +: 4];
      if (state_q == StNeg) begin
         x_dig = 4'd9 - r_dig;
         y_dig = 4'd0;
      end else begin
         x_dig = a_dig;
         y_dig = op_q ? (4'd9 - b_dig) : b_dig;
      end
      s_bin = {1'b0, x_dig} + {1'b0, y_dig} + {4'd0, carry_q};
      s_cor = s_bin + 5'd6;
      if (s_bin > 5'd9) begin
         sum_dig = s_cor[3:0];
         cout    = 1'b1;
      end else begin
         sum_dig = s_bin[3:0];
         cout    = 1'b0;
      end
      last = (cnt_q == CntW'(DIGITS - 1));
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      sign_d   = sign_q;
      ovf_d    = ovf_q;
      inv_d    = inv_q;
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               a_d      = bus.a;
               b_d      = bus.b;
               op_d     = bus.op;
               result_d = '0;
               sign_d   = 1'b0;
               ovf_d    = 1'b0;
               inv_d    = 1'b0;
               cnt_d    = '0;
               carry_d  = bus.op;
               if (has_bad_digit(bus.a) || has_bad_digit(bus.b)) begin
                  inv_d   = 1'b1;
                  state_d = StDone;
               end else begin
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            result_d[4*idx +: 4] = sum_dig;
            carry_d              = cout;
            if (last) begin
               cnt_d = '0;
               if (!op_q) begin
                  ovf_d   = cout;
                  state_d = StDone;
               end else if (cout) begin
                  sign_d  = 1'b0;
                  state_d = StDone;
               end else begin
                  carry_d = 1'b1;
                  state_d = StNeg;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StNeg: begin
            result_d[4*idx +: 4] = sum_dig;
            carry_d              = cout;
            if (last) begin
               cnt_d   = '0;
               carry_d = 1'b0;
               sign_d  = 1'b1;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         op_q     <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         sign_q   <= 1'b0;
         ovf_q    <= 1'b0;
         inv_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         sign_q   <= sign_d;
         ovf_q    <= ovf_d;
         inv_q    <= inv_d;
      end
   end

   assign bus.busy     = (state_q == StCalc) || (state_q == StNeg);
   assign bus.done     = (state_q == StDone);
   assign bus.result   = result_q;
   assign bus.sign     = sign_q;
   assign bus.overflow = ovf_q;
   assign bus.invalid  = inv_q;
endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Randomised and directed bench for bcd_serial_addsub at DIGITS = 1, 4 and 8 against an
// integer-arithmetic reference model.
module tb_bcd_serial_addsub;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bcd_serial_addsub_if #(.DIGITS(1)) u_if1 ();
   bcd_serial_addsub_if #(.DIGITS(4)) u_if4 ();
   bcd_serial_addsub_if #(.DIGITS(8)) u_if8 ();

   bcd_serial_addsub #(.DIGITS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(u_if1));
   bcd_serial_addsub #(.DIGITS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(u_if4));
   bcd_serial_addsub #(.DIGITS(8)) u_dut8 (.clk(clk), .rst(rst), .bus(u_if8));

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic set_in(input int nd, input logic st, input logic op,
                         input logic [31:0] a, input logic [31:0] b);
      case (nd)
         1: begin u_if1.start = st; u_if1.op = op; u_if1.a = a[3:0];  u_if1.b = b[3:0];  end
         4: begin u_if4.start = st; u_if4.op = op; u_if4.a = a[15:0]; u_if4.b = b[15:0]; end
         default: begin u_if8.start = st; u_if8.op = op; u_if8.a = a; u_if8.b = b; end
      endcase
   endtask

   task automatic get_out(input int nd, output logic bz, output logic dn, output logic [31:0] res,
                          output logic sg, output logic ov, output logic iv);
      case (nd)
         1: begin bz = u_if1.busy; dn = u_if1.done; res = 32'(u_if1.result);
                  sg = u_if1.sign; ov = u_if1.overflow; iv = u_if1.invalid; end
         4: begin bz = u_if4.busy; dn = u_if4.done; res = 32'(u_if4.result);
                  sg = u_if4.sign; ov = u_if4.overflow; iv = u_if4.invalid; end
         default: begin bz = u_if8.busy; dn = u_if8.done; res = u_if8.result;
                  sg = u_if8.sign; ov = u_if8.overflow; iv = u_if8.invalid; end
      endcase
   endtask

   function automatic longint from_bcd(input logic [31:0] x, input int nd);
      longint v = 0;
      for (int i = nd - 1; i >= 0; i--) v = v * 10 + longint'(x[4*i +: 4]);
      return v;
   endfunction

   function automatic logic [31:0] to_bcd(input longint v, input int nd);
      logic [31:0] r = '0;
      longint t = v;
      for (int i = 0; i < nd; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic is_bad(input logic [31:0] x, input int nd);
      logic bad = 1'b0;
      for (int i = 0; i < nd; i++) if (x[4*i +: 4] > 4'd9) bad = 1'b1;
      return bad;
   endfunction

   function automatic logic [31:0] rand_bcd(input int nd, input bit allow_bad);
      logic [31:0] r = '0;
      for (int i = 0; i < nd; i++) begin
         if (allow_bad && $urandom_range(0, 15) == 0) r[4*i +: 4] = 4'($urandom_range(10, 15));
         else r[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      return r;
   endfunction

   task automatic run_op(input int nd, input logic op, input logic [31:0] a, input logic [31:0] b,
                         input bit junk, input string tag);
      longint p10 = 1;
      longint av, bv, r;
      logic [31:0] e_res, res;
      logic e_sg, e_ov, e_iv, bz, dn, sg, ov, iv;
      int lat, k, busy_cnt;
      for (int i = 0; i < nd; i++) p10 = p10 * 10;
      e_sg = 1'b0; e_ov = 1'b0; e_iv = 1'b0;
      if (is_bad(a, nd) || is_bad(b, nd)) begin
         e_iv = 1'b1; e_res = '0; lat = 1;
      end else begin
         av = from_bcd(a, nd);
         bv = from_bcd(b, nd);
         if (!op) begin
            r = av + bv;
            e_ov = (r >= p10);
            e_res = to_bcd(r % p10, nd);
            lat = nd + 1;
         end else begin
            r = av - bv;
            e_sg = (r < 0);
            e_res = to_bcd(r < 0 ? -r : r, nd);
            lat = (r < 0) ? 2 * nd + 1 : nd + 1;
         end
      end
      @(negedge clk);
      set_in(nd, 1'b1, op, a, b);
      @(posedge clk);
      #1 set_in(nd, junk, 1'($urandom), rand_bcd(nd, 1'b1), rand_bcd(nd, 1'b1));
      k = 0;
      busy_cnt = 0;
      for (int i = 1; i <= 2 * nd + 8; i++) begin
         @(negedge clk);
         get_out(nd, bz, dn, res, sg, ov, iv);
         if (dn) begin
            k = i;
            break;
         end
         if (bz) busy_cnt++;
         if (junk) set_in(nd, 1'b1, 1'($urandom), rand_bcd(nd, 1'b0), rand_bcd(nd, 1'b0));
      end
      set_in(nd, 1'b0, 1'b0, '0, '0);
      check({tag, " latency"}, 64'(k), 64'(lat));
      check({tag, " result"}, 64'(res), 64'(e_res));
      check({tag, " sign"}, 64'(sg), 64'(e_sg));
      check({tag, " overflow"}, 64'(ov), 64'(e_ov));
      check({tag, " invalid"}, 64'(iv), 64'(e_iv));
      check({tag, " busy cycles"}, 64'(busy_cnt), 64'(lat - 1));
      @(negedge clk);
      get_out(nd, bz, dn, res, sg, ov, iv);
      check({tag, " idle after done"}, {62'd0, bz, dn}, 64'd0);
      check({tag, " result held"}, 64'(res), 64'(e_res));
   endtask

   initial begin
      logic [31:0] res;
      logic bz, dn, sg, ov, iv, saw_done;
      int nds[3] = '{1, 4, 8};
      rst = 1'b1;
      foreach (nds[j]) set_in(nds[j], 1'b0, 1'b0, '0, '0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      foreach (nds[j]) begin
         get_out(nds[j], bz, dn, res, sg, ov, iv);
         check($sformatf("reset outputs d%0d", nds[j]), {27'd0, res, bz, dn, sg, ov, iv}, 64'd0);
      end
      rst = 1'b0;

      run_op(4, 1'b0, 32'h1234, 32'h5678, 1'b0, "add 1234+5678");
      run_op(4, 1'b0, 32'h9999, 32'h0001, 1'b0, "add 9999+0001");
      run_op(4, 1'b0, 32'h0000, 32'h0000, 1'b0, "add 0000+0000");
      run_op(4, 1'b1, 32'h5000, 32'h1234, 1'b0, "sub 5000-1234");
      run_op(4, 1'b1, 32'h0042, 32'h0042, 1'b0, "sub 0042-0042");
      run_op(4, 1'b1, 32'h0012, 32'h0345, 1'b0, "sub 0012-0345");
      run_op(4, 1'b1, 32'h0000, 32'h9999, 1'b0, "sub 0000-9999");
      run_op(4, 1'b0, 32'h12A4, 32'h0001, 1'b0, "invalid 12A4");
      run_op(4, 1'b1, 32'h0012, 32'h0345, 1'b1, "start while busy");

      // Abort in the second CALC cycle; outputs from the previous op must clear.
      @(negedge clk);
      set_in(4, 1'b1, 1'b0, 32'h1234, 32'h5678);
      @(posedge clk);
      #1 set_in(4, 1'b0, 1'b0, '0, '0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      get_out(4, bz, dn, res, sg, ov, iv);
      check("abort outputs", {27'd0, res, bz, dn, sg, ov, iv}, 64'd0);
      saw_done = 1'b0;
      repeat (6) begin
         @(negedge clk);
         get_out(4, bz, dn, res, sg, ov, iv);
         if (dn || bz) saw_done = 1'b1;
      end
      check("abort no done", 64'(saw_done), 64'd0);
      run_op(4, 1'b0, 32'h0815, 32'h4711, 1'b0, "after abort");

      run_op(1, 1'b0, 32'h9, 32'h1, 1'b0, "d1 add 9+1");
      run_op(1, 1'b1, 32'h3, 32'h7, 1'b0, "d1 sub 3-7");
      run_op(8, 1'b1, 32'h00000001, 32'h99999999, 1'b0, "d8 sub 1-99999999");
      run_op(8, 1'b0, 32'h99999999, 32'h99999999, 1'b0, "d8 add max");

      for (int i = 0; i < 40; i++) begin
         int nd;
         nd = nds[i % 3];
         run_op(nd, 1'($urandom), rand_bcd(nd, 1'b1), rand_bcd(nd, 1'b1),
                ($urandom_range(0, 3) == 0), $sformatf("rand%0d d%0d", i, nd));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
